serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b, LSB first, one bit per clock.
- Uses a registered borrow chain around a single full-subtractor cell.
- Start/busy/done handshake; companion to the team's adder blocks for area-constrained datapaths (ALU labs, serial accumulators).
- Outputs are registered and held stable until the next accepted start.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  request; accepted only when FSM is IDLE
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
busy  output  1  high while bits are being processed (state SHIFT)
done  output  1  one-cycle pulse: diff/borrow/zero newly valid
diff  output  WIDTH  a - b modulo 2^WIDTH
borrow  output  1  final borrow out (1 when a < b, unsigned)
zero  output  1  high when diff == 0

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, busy=0, done=0, diff=0, borrow=0, zero=0, internal shift registers, bit counter and borrow flop all 0. Reset overrides everything, including mid-operation; no result is produced for an aborted operation.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: load a_sh<=a, b_sh<=b, br<=0, cnt<=0, state<=SHIFT.
  - start=0: remain in IDLE.
- SHIFT: at each edge E1..E_WIDTH, process bit cnt:
  - d = a_sh[0] ^ b_sh[0] ^ br
  - br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)
  - d shifts into the result register from the MSB end.
  - a_sh and b_sh shift right; cnt increments.
- At edge E_WIDTH (last bit, cnt == WIDTH-1): diff <= completed result, borrow <= br_next, zero <= (completed result == 0), state <= DONE.
- DONE: done=1 for exactly one cycle; next edge moves to IDLE and done returns to 0.
- Latency: done is high in the cycle after edge E_WIDTH. Start-to-start throughput is WIDTH+2 cycles.
- busy = (state == SHIFT). It is high for exactly WIDTH cycles per operation.
- start while in SHIFT or DONE: ignored. Operands are not re-captured, and the in-flight result is unaffected.
- Inputs a and b may change freely after capture without affecting the operation.
- diff, borrow and zero:
  - hold their previous values during SHIFT (no partial results visible);
  - update only at edge E_WIDTH;
  - remain unchanged through IDLE.
- cnt width is clog2(WIDTH). Terminal compare is cnt == WIDTH-1, so WIDTH need not be a power of two.
- Signed interpretation is the caller's responsibility. The block is two's-complement correct modulo 2^WIDTH, and borrow is the unsigned borrow.

Decomposition:
- Shared package/header:
  - state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - default WIDTH constant.
- One natural sub-module: full_subtractor_bit (inputs x, y, bin; outputs d, bout), purely combinational. It is instantiated once and built from two half-subtractor stages plus an OR for bout.
- FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
1. WIDTH=8; a=100, b=37, pulse start -> busy high 8 cycles, then done pulse; diff=63 (0x3F), borrow=0, zero=0.
2. a=37, b=100 -> diff=0xC1 (193), borrow=1, zero=0.
3. a=0x55, b=0x55 -> diff=0x00, borrow=0, zero=1. Then a=0x00, b=0x01 -> diff=0xFF, borrow=1, zero=0 (full borrow ripple).
4. Start a=200, b=50; re-assert start with a=1, b=1 and change inputs during SHIFT -> the second start is ignored; result diff=150, borrow=0; done exactly once; busy exactly 8 cycles.
5. Start a=9, b=3; drive rst_n=0 at edge E4 -> next cycle busy=0, done=0, diff=0, borrow=0, zero=0, state IDLE. A fresh start with a=9, b=3 then gives diff=6.
6. Back-to-back: pulse start in the cycle after done (IDLE) -> accepted; previous diff holds until the new E_WIDTH edge. Repeat for WIDTH=5 with a=3, b=7 -> diff=28 (0x1C), borrow=1.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_bit.sv
// One-bit full subtractor: two half-subtractor stages, borrows ORed together.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  assign d1   = x ^ y;
  assign b1   = ~x & y;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with a registered borrow chain.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, a_sh_next;
  logic [WIDTH-1:0] b_sh, b_sh_next;
  logic [WIDTH-1:0] res, res_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             br, br_next;
  logic [WIDTH-1:0] diff_next;
  logic             borrow_next;
  logic             zero_next;
  logic             busy_next;
  logic             done_next;
  logic             bit_d;
  logic             bit_bout;

  full_subtractor_bit u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (br),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_next  = state;
    a_sh_next   = a_sh;
    b_sh_next   = b_sh;
    res_next    = res;
    cnt_next    = cnt;
    br_next     = br;
    diff_next   = diff;
    borrow_next = borrow;
    zero_next   = zero;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          a_sh_next  = a;
          b_sh_next  = b;
          br_next    = 1'b0;
          cnt_next   = '0;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_next  = {bit_d, res[WIDTH-1:1]};
        a_sh_next = {1'b0, a_sh[WIDTH-1:1]};
        b_sh_next = {1'b0, b_sh[WIDTH-1:1]};
        br_next   = bit_bout;
        cnt_next  = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          // Only the completed result becomes visible.
          diff_next   = res_next;
          borrow_next = bit_bout;
          zero_next   = (res_next == '0);
          cnt_next    = '0;
          state_next  = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    busy_next = (state_next == S_SHIFT);
    done_next = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      a_sh   <= a_sh_next;
      b_sh   <= b_sh_next;
      res    <= res_next;
      cnt    <= cnt_next;
      br     <= br_next;
      diff   <= diff_next;
      borrow <= borrow_next;
      zero   <= zero_next;
      busy   <= busy_next;
      done   <= done_next;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed vector bench for serial_subtractor at WIDTH=8 and WIDTH=5.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start8, start5;
  logic [7:0] a8, b8;
  logic [4:0] a5, b5;
  logic       busy8, done8, borrow8, zero8;
  logic [7:0] diff8;
  logic       busy5, done5, borrow5, zero5;
  logic [4:0] diff5;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev8 = 8'h00;
  logic [7:0] prev5 = 8'h00;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .a(a5), .b(b5),
    .busy(busy5), .done(done5), .diff(diff5), .borrow(borrow5), .zero(zero5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
    logic       z;
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_busy(input bit w5);
    return w5 ? busy5 : busy8;
  endfunction

  function automatic logic get_done(input bit w5);
    return w5 ? done5 : done8;
  endfunction

  function automatic logic [7:0] get_diff(input bit w5);
    return w5 ? {3'b000, diff5} : diff8;
  endfunction

  // One operation from IDLE; noise re-asserts start with junk operands during SHIFT.
  task automatic op(input bit w5, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] ed, input logic eb, input logic ez,
                    input bit noise, input string name);
    int nbusy = 0;
    int ndone = 0;
    bit held = 1'b1;
    bit got = 1'b0;
    logic [7:0] prev = w5 ? prev5 : prev8;
    if (w5) begin start5 = 1'b1; a5 = a[4:0]; b5 = b[4:0]; end
    else    begin start8 = 1'b1; a8 = a;      b8 = b;      end
    tick();
    start8 = 1'b0;
    start5 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (noise && i < 4) begin
        start8 = 1'b1; a8 = 8'h01 + 8'(i); b8 = 8'h01;
      end else if (noise) begin
        start8 = 1'b0;
      end
      if (get_done(w5)) begin
        got = 1'b1;
        ndone++;
        break;
      end
      if (get_busy(w5)) nbusy++;
      if (get_diff(w5) !== prev) held = 1'b0;
      tick();
    end
    start8 = 1'b0;
    check({name, " timeout"}, 32'(got), 32'd1);
    check({name, " busy_cycles"}, 32'(nbusy), w5 ? 32'd5 : 32'd8);
    check({name, " diff_held"}, 32'(held), 32'd1);
    check({name, " diff"}, 32'(get_diff(w5)), 32'(ed));
    check({name, " borrow"}, 32'(w5 ? borrow5 : borrow8), 32'(eb));
    check({name, " zero"}, 32'(w5 ? zero5 : zero8), 32'(ez));
    tick();
    if (get_done(w5)) ndone++;
    check({name, " done_once"}, 32'(ndone), 32'd1);
    check({name, " idle_busy"}, 32'(get_busy(w5)), 32'd0);
    if (w5) prev5 = ed; else prev8 = ed;
  endtask

  initial begin
    vecs[0] = '{8'd100,  8'd37,  8'd63,  1'b0, 1'b0, "v100_37"};
    vecs[1] = '{8'd37,   8'd100, 8'hC1,  1'b1, 1'b0, "v37_100"};
    vecs[2] = '{8'h55,   8'h55,  8'h00,  1'b0, 1'b1, "v55_55"};
    vecs[3] = '{8'h00,   8'h01,  8'hFF,  1'b1, 1'b0, "v00_01"};
    vecs[4] = '{8'hFF,   8'h00,  8'hFF,  1'b0, 1'b0, "vFF_00"};
    vecs[5] = '{8'h80,   8'h01,  8'h7F,  1'b0, 1'b0, "v80_01"};

    rst_n = 1'b0; start8 = 1'b0; start5 = 1'b0;
    a8 = '0; b8 = '0; a5 = '0; b5 = '0;
    tick();
    tick();
    check("rst busy", 32'(busy8), 32'd0);
    check("rst done", 32'(done8), 32'd0);
    check("rst diff", 32'(diff8), 32'd0);
    check("rst borrow", 32'(borrow8), 32'd0);
    check("rst zero", 32'(zero8), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table vectors run back to back: each start lands in the IDLE cycle after done.
    foreach (vecs[i])
      op(1'b0, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].z, 1'b0, vecs[i].name);

    op(1'b0, 8'd200, 8'd50, 8'd150, 1'b0, 1'b0, 1'b1, "ignored_start");

    // Abort mid-operation: reset lands on edge E4.
    a8 = 8'd9; b8 = 8'd3; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'hAA; b8 = 8'h55;
    tick();
    tick();
    tick();
    check("abort busy_before", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort busy", 32'(busy8), 32'd0);
    check("abort done", 32'(done8), 32'd0);
    check("abort diff", 32'(diff8), 32'd0);
    check("abort borrow", 32'(borrow8), 32'd0);
    check("abort zero", 32'(zero8), 32'd0);
    rst_n = 1'b1;
    prev8 = 8'h00;
    prev5 = 8'h00;
    tick();
    check("abort stays_idle", 32'(busy8), 32'd0);
    op(1'b0, 8'd9, 8'd3, 8'd6, 1'b0, 1'b0, 1'b0, "after_abort");
    op(1'b0, 8'd3, 8'd9, 8'hFA, 1'b1, 1'b0, 1'b0, "b2b_3_9");

    op(1'b1, 8'd3, 8'd7, 8'd28, 1'b1, 1'b0, 1'b0, "w5_3_7");
    op(1'b1, 8'd31, 8'd2, 8'd29, 1'b0, 1'b0, 1'b0, "w5_31_2");
    op(1'b1, 8'd17, 8'd17, 8'd0, 1'b0, 1'b1, 1'b0, "w5_17_17");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
